// File: rtl/peaton_solicitud.sv
// -----------------------------------------------------------------------------
// peaton_solicitud
//   Pedestrian crossing request block for two independent crossings. Each
//   channel conditions a bouncing pushbutton and runs a request/walk/lockout
//   sequence, handshaking with the traffic controller via the red lamp.
//
//   Handshake (per channel n): boton_n is a level request that stays high
//   while the channel is pending; the controller acknowledges by lighting
//   led_r_n (red for vehicles). The request drops as soon as the acknowledge
//   is seen, walk_n is lit for up to WALK_CYCLES cycles (cut short if the red
//   lamp goes out) and a HOLD_CYCLES lockout follows, during which new
//   requests are ignored.
//
//   Ports
//     clk_i                 system clock (single domain)
//     rst_i                 asynchronous active-low reset
//     btn_raw_1/2           raw pushbuttons, asynchronous, active-high
//     led_r_1/2             vehicle red lamp state from the traffic controller
//     boton_1/2             registered crossing request to the controller
//     wait_1/2              registered "request pending" lamp
//     walk_1/2              registered pedestrian walk lamp
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// peaton_canal
//   One crossing channel: 2-flop synchronizers, debouncer, press detector and
//   the IDLE/PEND/WALK/HOLD sequencer with registered outputs.
//
//   Ports
//     clk_i, rst_i   clock, asynchronous active-low reset
//     i_btn_raw      raw pushbutton
//     i_led_r        vehicle red lamp (acknowledge)
//     o_boton        request level
//     o_wait         pending lamp
//     o_walk         walk lamp
//     o_state        current sequencer state (debug observation)
// -----------------------------------------------------------------------------
module peaton_canal #(
  parameter int DEB_CYCLES  = 1000000,
  parameter int WALK_CYCLES = 500000000,
  parameter int HOLD_CYCLES = 250000000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       i_btn_raw,
  input  logic       i_led_r,
  output logic       o_boton,
  output logic       o_wait,
  output logic       o_walk,
  output logic [1:0] o_state
);

  localparam int DEB_W  = (DEB_CYCLES  > 1) ? $clog2(DEB_CYCLES)  : 1;
  localparam int WALK_W = (WALK_CYCLES > 1) ? $clog2(WALK_CYCLES) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [WALK_W-1:0] WALK_LAST = WALK_W'(WALK_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_WALK = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  logic              r_btn_s1, r_btn_s2;
  logic              r_led_s1, r_led_s2;
  logic [DEB_W-1:0]  r_deb_cnt;
  logic              r_deb;
  logic              r_deb_d;
  logic              w_press;
  state_t            r_state;
  logic [WALK_W-1:0] r_walk_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_boton, r_wait, r_walk;

  // Synchronizers and debouncer. The counter measures how long the
  // synchronized button has disagreed with the accepted level; any agreement
  // restarts the qualification, so a bouncing contact never gets through.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_btn_s1  <= 1'b0;
      r_btn_s2  <= 1'b0;
      r_led_s1  <= 1'b0;
      r_led_s2  <= 1'b0;
      r_deb_cnt <= '0;
      r_deb     <= 1'b0;
      r_deb_d   <= 1'b0;
    end else begin
      r_btn_s1 <= i_btn_raw;
      r_btn_s2 <= r_btn_s1;
      r_led_s1 <= i_led_r;
      r_led_s2 <= r_led_s1;
      r_deb_d  <= r_deb;
      if (r_btn_s2 != r_deb) begin
        if (r_deb_cnt == DEB_LAST) begin
          r_deb     <= r_btn_s2;
          r_deb_cnt <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + DEB_W'(1);
        end
      end else begin
        r_deb_cnt <= '0;
      end
    end
  end

  // Only a rising debounced level counts; a button held through the lockout
  // shows no edge and therefore no request afterwards.
  assign w_press = r_deb & ~r_deb_d;

  // Sequencer with outputs registered together with the state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= ST_IDLE;
      r_walk_cnt <= '0;
      r_hold_cnt <= '0;
      r_boton    <= 1'b0;
      r_wait     <= 1'b0;
      r_walk     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_press) begin
            r_state <= ST_PEND;
            r_boton <= 1'b1;
            r_wait  <= 1'b1;
          end
        end
        ST_PEND: begin
          if (r_led_s2) begin
            r_state    <= ST_WALK;
            r_boton    <= 1'b0;
            r_wait     <= 1'b0;
            r_walk     <= 1'b1;
            r_walk_cnt <= '0;
          end
        end
        ST_WALK: begin
          // Losing the red lamp ends the walk immediately, even on the
          // cycle the timer would have expired anyway.
          if (!r_led_s2 || (r_walk_cnt == WALK_LAST)) begin
            r_state    <= ST_HOLD;
            r_walk     <= 1'b0;
            r_hold_cnt <= '0;
          end else begin
            r_walk_cnt <= r_walk_cnt + WALK_W'(1);
          end
        end
        ST_HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_boton <= 1'b0;
          r_wait  <= 1'b0;
          r_walk  <= 1'b0;
        end
      endcase
    end
  end

  assign o_boton = r_boton;
  assign o_wait  = r_wait;
  assign o_walk  = r_walk;
  assign o_state = r_state;

endmodule

module peaton_solicitud #(
  parameter int DEB_CYCLES  = 1000000,
  parameter int WALK_CYCLES = 500000000,
  parameter int HOLD_CYCLES = 250000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_raw_1,
  input  logic btn_raw_2,
  input  logic led_r_1,
  input  logic led_r_2,
  output logic boton_1,
  output logic boton_2,
  output logic wait_1,
  output logic wait_2,
  output logic walk_1,
  output logic walk_2
);

  // Per-channel sequencer state, kept visible for debug probing.
  logic [1:0] w_state_1;
  logic [1:0] w_state_2;

  peaton_canal #(
    .DEB_CYCLES (DEB_CYCLES),
    .WALK_CYCLES(WALK_CYCLES),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_canal_1 (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_btn_raw(btn_raw_1),
    .i_led_r  (led_r_1),
    .o_boton  (boton_1),
    .o_wait   (wait_1),
    .o_walk   (walk_1),
    .o_state  (w_state_1)
  );

  peaton_canal #(
    .DEB_CYCLES (DEB_CYCLES),
    .WALK_CYCLES(WALK_CYCLES),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_canal_2 (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_btn_raw(btn_raw_2),
    .i_led_r  (led_r_2),
    .o_boton  (boton_2),
    .o_wait   (wait_2),
    .o_walk   (walk_2),
    .o_state  (w_state_2)
  );

endmodule

// File: tb/tb_peaton_solicitud.sv
// -----------------------------------------------------------------------------
// tb_peaton_solicitud
//   Bench for peaton_solicitud with DEB_CYCLES=4, WALK_CYCLES=10,
//   HOLD_CYCLES=6. Output vector order everywhere:
//   {boton_1, wait_1, walk_1, boton_2, wait_2, walk_2}.
// -----------------------------------------------------------------------------
module tb_peaton_solicitud;

  localparam int DEB  = 4;
  localparam int WALK = 10;
  localparam int HOLD = 6;
  localparam int HL   = DEB + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic btn1, btn2, led1, led2;
  logic boton_1, boton_2, wait_1, wait_2, walk_1, walk_2;
  logic [5:0] dut_out;

  always #5 clk = ~clk;

  peaton_solicitud #(
    .DEB_CYCLES (DEB),
    .WALK_CYCLES(WALK),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .btn_raw_1(btn1),
    .btn_raw_2(btn2),
    .led_r_1  (led1),
    .led_r_2  (led2),
    .boton_1  (boton_1),
    .boton_2  (boton_2),
    .wait_1   (wait_1),
    .wait_2   (wait_2),
    .walk_1   (walk_1),
    .walk_2   (walk_2)
  );

  assign dut_out = {boton_1, wait_1, walk_1, boton_2, wait_2, walk_2};

  int total = 0;
  int bad   = 0;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic b1, input logic l1, input logic b2, input logic l2);
    btn1 = b1;
    led1 = l1;
    btn2 = b2;
    led2 = l2;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Works from input history: the debounced level flips at an edge when the
  // synchronized button (raw value two edges old) disagreed with it for the
  // whole previous DEB-cycle window. Phases are timed by edge stamps.
  bit bh [2][HL];
  bit lh [2][HL];
  bit deb [2];
  bit deb_p [2];
  int mp [2];   // 0 idle, 1 pending, 2 walk, 3 lockout
  int t0 [2];
  int k;

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < HL; i++) begin
        bh[c][i] = 1'b0;
        lh[c][i] = 1'b0;
      end
      deb[c]   = 1'b0;
      deb_p[c] = 1'b0;
      mp[c]    = 0;
      t0[c]    = 0;
    end
    k = 0;
  endtask

  task automatic model_step(input int ch, input bit b, input bit l);
    bit rose, lsync, all_diff;
    for (int i = HL - 1; i > 0; i--) begin
      bh[ch][i] = bh[ch][i-1];
      lh[ch][i] = lh[ch][i-1];
    end
    bh[ch][0] = b;
    lh[ch][0] = l;
    rose  = deb[ch] && !deb_p[ch];
    lsync = lh[ch][2];
    all_diff = 1'b1;
    for (int i = 2; i <= DEB + 1; i++)
      if (bh[ch][i] == deb[ch]) all_diff = 1'b0;
    deb_p[ch] = deb[ch];
    if (all_diff) deb[ch] = !deb[ch];
    case (mp[ch])
      0: if (rose) mp[ch] = 1;
      1: if (lsync) begin mp[ch] = 2; t0[ch] = k; end
      2: if (!lsync || (k - t0[ch] >= WALK)) begin mp[ch] = 3; t0[ch] = k; end
      default: if (k - t0[ch] >= HOLD) mp[ch] = 0;
    endcase
  endtask

  function automatic logic [2:0] model_out(input int ch);
    return {mp[ch] == 1, mp[ch] == 1, mp[ch] == 2};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic       b1, l1, b2, l2;
    int         n;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl [26];

  function automatic vec_t mk(input logic b1, input logic l1, input logic b2,
                              input logic l2, input int n, input logic [5:0] e);
    vec_t v;
    v.b1 = b1; v.l1 = l1; v.b2 = b2; v.l2 = l2; v.n = n; v.exp = e;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  logic [5:0] exp_q [$];
  int         hold_left [4];
  bit         val [4];

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_state", dut_out, 6'b000000);

    // Edge counts below are measured from the first edge after reset release.
    tbl[0]  = mk(1, 0, 0, 0, 6,  6'b000000);  // qualifying press
    tbl[1]  = mk(1, 0, 0, 0, 1,  6'b110000);  // request at edge 7
    tbl[2]  = mk(1, 0, 0, 0, 5,  6'b110000);  // pending, waiting for red
    tbl[3]  = mk(0, 1, 0, 0, 2,  6'b110000);  // red through synchronizer
    tbl[4]  = mk(0, 1, 0, 0, 1,  6'b001000);  // walk 3 edges after red
    tbl[5]  = mk(0, 1, 0, 0, 9,  6'b001000);  // full walk length
    tbl[6]  = mk(0, 1, 0, 0, 1,  6'b000000);  // lockout after 10 walk cycles
    tbl[7]  = mk(0, 0, 0, 0, 5,  6'b000000);  // lockout
    tbl[8]  = mk(1, 0, 0, 0, 6,  6'b000000);  // new press once idle again
    tbl[9]  = mk(1, 0, 0, 0, 1,  6'b110000);
    tbl[10] = mk(0, 1, 0, 0, 3,  6'b001000);  // walk
    tbl[11] = mk(0, 1, 0, 0, 3,  6'b001000);  // 4 walk cycles so far
    tbl[12] = mk(0, 0, 0, 0, 2,  6'b001000);  // red dropped, in synchronizer
    tbl[13] = mk(0, 0, 0, 0, 1,  6'b000000);  // walk aborted 3 edges later
    tbl[14] = mk(0, 0, 0, 0, 5,  6'b000000);
    tbl[15] = mk(0, 0, 0, 0, 1,  6'b000000);  // idle
    tbl[16] = mk(1, 1, 0, 0, 6,  6'b000000);  // press with red already lit
    tbl[17] = mk(1, 1, 0, 0, 1,  6'b110000);  // request for one cycle only
    tbl[18] = mk(1, 1, 0, 0, 1,  6'b001000);
    tbl[19] = mk(1, 1, 0, 0, 9,  6'b001000);
    tbl[20] = mk(1, 1, 0, 0, 1,  6'b000000);
    tbl[21] = mk(1, 1, 0, 0, 6,  6'b000000);  // back to idle, button held
    tbl[22] = mk(1, 1, 0, 0, 10, 6'b000000);  // held button: no new request
    tbl[23] = mk(0, 0, 0, 0, 8,  6'b000000);  // release
    tbl[24] = mk(1, 0, 0, 0, 6,  6'b000000);  // press again
    tbl[25] = mk(1, 0, 0, 0, 1,  6'b110000);

    do_reset();
    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].b1, tbl[i].l1, tbl[i].b2, tbl[i].l2);
      repeat (tbl[i].n) step();
      check($sformatf("tbl[%0d]", i), dut_out, tbl[i].exp);
    end

    // Bouncing button on channel 2: toggles every 2 cycles, never qualifies.
    do_reset();
    for (int c = 0; c < 40; c++) begin
      drive(1'b0, 1'b0, ((c / 2) % 2) == 0, 1'b0);
      step();
      check($sformatf("bounce[%0d]", c), dut_out, 6'b000000);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (6) step();
    check("steady_pre", dut_out, 6'b000000);
    step();
    check("steady_req", dut_out, 6'b000110);

    // Channel 1 into walk while channel 2 stays pending, then reset mid-walk.
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (7) step();
    check("mix_pend", dut_out, 6'b110110);
    step();
    check("mix_walk", dut_out, 6'b001110);
    repeat (3) step();
    check("mix_walk_mid", dut_out, 6'b001110);
    #3 rst_n = 1'b0;
    #1;
    check("async_reset", dut_out, 6'b000000);
    step();
    check("reset_held", dut_out, 6'b000000);
    rst_n = 1'b1;
    repeat (6) step();
    check("post_reset_qual", dut_out, 6'b000000);
    step();
    check("post_reset_req", dut_out, 6'b110110);
    step();
    check("post_reset_walk", dut_out, 6'b001110);

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    for (int j = 0; j < 4; j++) hold_left[j] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int j = 0; j < 4; j++) begin
        if (hold_left[j] == 0) begin
          val[j] = 1'($urandom_range(0, 1));
          hold_left[j] = (j < 2) ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 30));
        end
        hold_left[j]--;
      end
      drive(val[0], val[2], val[1], val[3]);
      @(posedge clk);
      k++;
      model_step(0, val[0], val[2]);
      model_step(1, val[1], val[3]);
      exp_q.push_back({model_out(0), model_out(1)});
      #1;
      check($sformatf("rand[%0d]", c), dut_out, exp_q.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/peaton_solicitud.md
PEATON_SOLICITUD -- requirements
Module: peaton_solicitud

Interface
REQ-001 Parameter DEB_CYCLES, default 1000000: consecutive cycles a synchronized button level must hold to be accepted (20 ms at 50 MHz).
REQ-002 Parameter WALK_CYCLES, default 500000000: maximum length of the walk phase (10 s).
REQ-003 Parameter HOLD_CYCLES, default 250000000: lockout after a walk phase ends (5 s).
REQ-004 clk_i  input  1  50 MHz system clock, single clock domain.
REQ-005 rst_i  input  1  reset, asynchronous, active-low.
REQ-006 btn_raw_1, btn_raw_2  input  1 each  raw pedestrian pushbuttons, asynchronous, active-high, bouncing.
REQ-007 led_r_1, led_r_2  input  1 each  red lamp of vehicle signal 1/2 from the traffic controller; high is the acknowledge that pedestrians may cross.
REQ-008 boton_1, boton_2  output  1 each  crossing request level to the traffic controller, registered.
REQ-009 wait_1, wait_2  output  1 each  "request pending" pedestrian lamp, registered.
REQ-010 walk_1, walk_2  output  1 each  pedestrian walk lamp, registered.

Function
REQ-011 Channels 1 and 2 shall be identical and fully independent; each has its own synchronizer, debouncer, FSM and counters.
REQ-012 btn_raw_n and led_r_n shall each pass through a 2-flop synchronizer before any use.
REQ-013 Debouncer: counter increments each cycle synchronized button differs from the debounced level and clears when they match; when the counter reaches DEB_CYCLES-1 while still differing, the debounced level takes the new value on the next edge.
REQ-014 A press event is a 0->1 transition of the debounced level; falling transitions generate no event.
REQ-015 FSM states: IDLE, PEND, WALK, HOLD; reset state IDLE.
REQ-016 IDLE -> PEND on a press event, registered on the edge after the debounced level rises: boton_n rises DEB_CYCLES+3 edges after the first edge sampling btn_raw_n high.
REQ-017 PEND: boton_n=1, wait_n=1, walk_n=0; PEND -> WALK on the first cycle synchronized led_r_n=1, including the cycle after entry if red is already lit (boton_n then high exactly 1 cycle).
REQ-018 WALK: boton_n=0, wait_n=0, walk_n=1; walk counter starts at 0 on entry.
REQ-019 WALK -> HOLD when the walk counter reaches WALK_CYCLES-1 or when synchronized led_r_n=0, whichever first (abort on red loss has priority in the same cycle).
REQ-020 HOLD: all three outputs 0; hold counter starts at 0 on entry; HOLD -> IDLE when it reaches HOLD_CYCLES-1.
REQ-021 Press events in PEND, WALK or HOLD shall be discarded, not queued; a button held through HOLD shall not create an event on returning to IDLE.
REQ-022 Counters shall be sized ceil(log2(param)) bits and never wrap; they stop at their terminal value.
REQ-023 All outputs are direct register outputs; no combinational path from any input to any output.

Reset
REQ-024 rst_i low shall immediately force all outputs to 0, FSMs to IDLE, debounced levels, synchronizers and counters to 0, regardless of state.
REQ-025 After rst_i rises, a button already held shall produce a press event only after the full DEB_CYCLES qualification.

Verification (DEB_CYCLES=4, WALK_CYCLES=10, HOLD_CYCLES=6)
REQ-026 btn_raw_1 high steady, led_r_1=0 -> boton_1 and wait_1 rise at edge 7, remain high; channel 2 outputs stay 0.
REQ-027 From PEND, led_r_1 raised -> 3 edges later walk_1=1, boton_1=0; walk_1 held exactly 10 cycles, then 6 cycles all-zero, then IDLE.
REQ-028 btn_raw_2 toggling every 2 cycles for 40 cycles -> boton_2 never asserts; then steady high -> boton_2 at edge 7 after steady.
REQ-029 In WALK, led_r_1 dropped after 4 walk cycles -> walk_1 falls 3 edges after the drop, HOLD entered, 6 cycles later IDLE.
REQ-030 Second press during WALK and during HOLD -> no new PEND; button held throughout -> remains IDLE until released and pressed again.
REQ-031 rst_i pulsed low mid-WALK on channel 1 while channel 2 in PEND -> all six outputs 0 asynchronously, both FSMs restart from IDLE.
